// File: rtl/mod_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_down_counter
// Description : Modulo-MOD down counter (MOD-1 .. 0) with clamped parallel load.
//               Terminal-count behaviour: define MOD_DOWN_COUNTER_AUTORELOAD_EN
//               for free-running reload with a wrap pulse; leave it undefined
//               for one-shot hold at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_down_counter #(
    parameter int BITS = 4,
    parameter int MOD  = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    output logic [BITS-1:0] Q,
    output logic            done,
    output logic            wrap
);

    localparam logic [BITS-1:0] c_max = BITS'(MOD - 1);

    generate
        if (MOD < 2 || MOD > (2 ** BITS)) begin : g_param_check
            $error("mod_down_counter: MOD must satisfy 2 <= MOD <= 2**BITS");
        end
    endgenerate

    logic [BITS-1:0] r_q;
    logic            w_zero;
    logic [BITS-1:0] w_load_clamped;
    logic [BITS-1:0] w_terminal_next;

    assign w_zero         = (r_q == '0);
    assign w_load_clamped = (load_value > c_max) ? c_max : load_value;

`ifdef MOD_DOWN_COUNTER_AUTORELOAD_EN
    assign w_terminal_next = c_max;
    assign wrap            = enable & ~load & ~reset & w_zero;
`else
    // One-shot: the count parks at zero until a load or reset restarts it.
    assign w_terminal_next = '0;
    assign wrap            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= c_max;
        end else if (load) begin
            r_q <= w_load_clamped;
        end else if (enable) begin
            r_q <= w_zero ? w_terminal_next : (r_q - 1'b1);
        end
    end

    assign Q    = r_q;
    assign done = w_zero;

endmodule
`default_nettype wire

// File: tb/tb_mod_down_counter.sv
`default_nettype none
// Testbench for mod_down_counter: directed and random steps checked against
// a behavioural integer model of the counter.
module tb_mod_down_counter;

    localparam int BITS = 4;
    localparam int MOD  = 13;

`ifdef MOD_DOWN_COUNTER_AUTORELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic            load = 1'b0;
    logic [BITS-1:0] load_value = '0;
    logic [BITS-1:0] Q;
    logic            done;
    logic            wrap;

    int n_assert = 0;
    int n_fail   = 0;
    int mq       = -1;   // model count; negative until the first reset
    int wrap_cnt = 0;

    mod_down_counter #(.BITS(BITS), .MOD(MOD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .Q          (Q),
        .done       (done),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, check state.
    task automatic step(input bit r, input bit l, input int lv, input bit e);
        int exp_wrap;
        reset      = r;
        load       = l;
        load_value = BITS'(lv);
        enable     = e;
        #1;
        if (mq >= 0) begin
            exp_wrap = (RELOAD && e && !l && !r && mq == 0) ? 1 : 0;
            wrap_cnt += exp_wrap;
            check("wrap_pre_edge", int'(wrap), exp_wrap);
            check("q_between_edges", int'(Q), mq);
        end
        @(posedge clk);
        if (r)           mq = MOD - 1;
        else if (l)      mq = (lv > MOD - 1) ? MOD - 1 : lv;
        else if (e) begin
            if (mq > 0)      mq = mq - 1;
            else if (RELOAD) mq = MOD - 1;
            else             mq = 0;
        end
        @(negedge clk);
        check("q_after_edge", int'(Q), mq);
        check("done_after_edge", int'(done), (mq == 0) ? 1 : 0);
    endtask

    initial begin
        int wraps_before;
        @(negedge clk);

        // Reset
        step(1, 0, 0, 0);
        check("reset_q", int'(Q), MOD - 1);
        check("reset_wrap", int'(wrap), 0);

        // Countdown: 20 enabled edges (wraps once in reload mode, parks at 0 otherwise)
        wraps_before = wrap_cnt;
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        check("wrap_count_20_edges", wrap_cnt - wraps_before, RELOAD ? 1 : 0);

        // Load and clamp
        step(0, 1, 5, 0);
        check("load_5", int'(Q), 5);
        step(0, 1, 15, 0);
        check("load_clamp_15", int'(Q), MOD - 1);
        step(0, 1, 0, 0);
        check("load_0_done", int'(done), 1);
        step(0, 1, 7, 1);
        check("load_with_enable_at_0", int'(Q), 7);

        // Priority: reset over load and enable, then hold
        step(1, 1, 3, 1);
        check("priority_reset", int'(Q), MOD - 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("hold_4", int'(Q), MOD - 1);

        // Mid-count reset
        for (int i = 0; i < MOD - 5; i++) step(0, 0, 0, 1);
        check("reached_4", int'(Q), 4);
        step(1, 0, 0, 0);
        check("mid_reset", int'(Q), MOD - 1);
        step(0, 0, 0, 1);
        check("resume_11", int'(Q), MOD - 2);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, (1 << BITS) - 1)),
                 ($urandom_range(0, 3) != 0));
            check("q_in_range", (int'(Q) <= MOD - 1) ? 1 : 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
